// File: rtl/e_pkg.sv
// ---------------------------------------------------------------------------------------------
// e_pkg
//   Shared types and helpers for the elevator floor tracker.
//   E_N_FLR        default floor count
//   e_dir_t        travel direction of the car
//   e_onehot2idx() one-hot to binary index encode (bit positions OR-ed together)
// ---------------------------------------------------------------------------------------------
package e_pkg;

  localparam int unsigned E_N_FLR = 4;

  typedef enum logic {
    E_DIR_DOWN = 1'b0,
    E_DIR_UP   = 1'b1
  } e_dir_t;

  // Encodes a one-hot vector. Only meaningful for exactly one set bit, which the car position
  // guarantees; OR-ing the indices keeps the logic a plain encoder with no priority chain.
  function automatic int unsigned e_onehot2idx(input logic [31:0] i_onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i_onehot[i]) begin
        idx = idx | i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/e_btn_cond.sv
// ---------------------------------------------------------------------------------------------
// e_btn_cond
//   Conditions one raw pushbutton: multi-flop synchroniser, optional debounce filter, and a
//   single-cycle rising-edge pulse.
//   Build option: E_DEBOUNCE_EN adds a saturating-counter filter after the synchroniser.
//   Ports:
//     i_clk   system clock
//     i_rst   asynchronous active-high reset
//     i_btn   raw button level, asynchronous to i_clk
//     o_rise  one-cycle pulse on a qualified press (combinational from registers)
// ---------------------------------------------------------------------------------------------
module e_btn_cond #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("e_btn_cond: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("e_btn_cond: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  // Tracks which synchroniser stages hold post-reset samples rather than reset zeros.
  logic [SYNC_STAGES-1:0] r_valid;
  logic                   r_armed;
  logic                   r_prev;
  logic                   w_sync;
  logic                   w_valid;
  logic                   w_level;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_valid = r_valid[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_valid <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
      // A button must be seen released after reset before any press counts, so a button held
      // through reset never turns into a request.
      r_armed <= r_armed | (w_valid & ~w_sync);
    end
  end

`ifdef E_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;

  // The filtered level follows the synced level only after DEBOUNCE_CYCLES consecutive samples
  // that differ from it; any agreeing sample restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_sync == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt  <= '0;
      r_filt <= w_sync;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = w_sync;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_rise = w_level & ~r_prev & r_armed;

endmodule

// File: rtl/e_floor_tracker.sv
// ---------------------------------------------------------------------------------------------
// e_floor_tracker
//   Request/position side of the elevator handshake. Latches call buttons into a pending
//   request vector and keeps the one-hot car position and travel direction. The elevator FSM
//   pulses ShiftFlr to advance the car and holds clearFlr to service the current floor.
//   Build option: E_DEBOUNCE_EN enables per-button debounce filtering (longer press latency).
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous active-high reset
//     btn_raw   raw call buttons, active-high, asynchronous
//     ShiftFlr  one-cycle pulse: move the car one floor
//     clearFlr  level: drop the request of the current floor
//     bts       pending requests, bit i = floor i
//     curFlr    one-hot car position, bit 0 = ground floor
//     flr_idx   binary index of curFlr
//     dir_up    1 = travelling up, 0 = down
// ---------------------------------------------------------------------------------------------
module e_floor_tracker
  import e_pkg::*;
#(
  parameter int unsigned N_FLR           = E_N_FLR,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_FLR-1:0]         btn_raw,
  input  logic                     ShiftFlr,
  input  logic                     clearFlr,
  output logic [N_FLR-1:0]         bts,
  output logic [N_FLR-1:0]         curFlr,
  output logic [$clog2(N_FLR)-1:0] flr_idx,
  output logic                     dir_up
);

  localparam int unsigned IDX_W = $clog2(N_FLR);

  logic [N_FLR-1:0] w_rise;
  logic [N_FLR-1:0] r_bts;
  logic [N_FLR-1:0] w_bts_d;
  logic [N_FLR-1:0] r_cur;
  logic [N_FLR-1:0] w_cur_d;
  logic [N_FLR-1:0] w_below;
  logic [N_FLR-1:0] w_above;
  logic [N_FLR-1:0] w_ahead;
  logic [N_FLR-1:0] w_behind;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_d;
  e_dir_t           r_dir;
  e_dir_t           w_dir_d;

  for (genvar i = 0; i < N_FLR; i++) begin : g_btn
    e_btn_cond #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_cond (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_btn  (btn_raw[i]),
      .o_rise (w_rise[i])
    );
  end

  always_comb begin
    // With a one-hot position, subtracting one yields exactly the floors below it.
    w_below  = r_cur - N_FLR'(1);
    w_above  = ~(w_below | r_cur);
    w_ahead  = r_bts & ((r_dir == E_DIR_UP) ? w_above : w_below);
    w_behind = r_bts & ((r_dir == E_DIR_UP) ? w_below : w_above);

    w_bts_d = r_bts | w_rise;
    w_cur_d = r_cur;
    w_dir_d = r_dir;

    if (ShiftFlr) begin
      // A move only happens toward an existing request, so the shift can never run off either
      // end of the vector and the position stays one-hot.
      if (|w_ahead) begin
        w_cur_d = (r_dir == E_DIR_UP) ? (r_cur << 1) : (r_cur >> 1);
      end else if (|w_behind) begin
        w_dir_d = (r_dir == E_DIR_UP) ? E_DIR_DOWN : E_DIR_UP;
        w_cur_d = (r_dir == E_DIR_UP) ? (r_cur >> 1) : (r_cur << 1);
      end
    end else if (clearFlr) begin
      // Clearing wins over a same-cycle press on the current floor.
      w_bts_d = (r_bts | w_rise) & ~r_cur;
    end

    w_idx_d = IDX_W'(e_onehot2idx(32'(w_cur_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bts <= '0;
      r_cur <= N_FLR'(1);
      r_idx <= '0;
      r_dir <= E_DIR_UP;
    end else begin
      r_bts <= w_bts_d;
      r_cur <= w_cur_d;
      r_idx <= w_idx_d;
      r_dir <= w_dir_d;
    end
  end

  assign bts     = r_bts;
  assign curFlr  = r_cur;
  assign flr_idx = r_idx;
  assign dir_up  = (r_dir == E_DIR_UP);

endmodule

// File: tb/tb_e_floor_tracker.sv
// ---------------------------------------------------------------------------------------------
// tb_e_floor_tracker
//   Self-checking bench for e_floor_tracker. Stimulus pushes hand-computed expected outputs into
//   a queue; a monitor on the falling clock edge pops and compares against the DUT.
// ---------------------------------------------------------------------------------------------
module tb_e_floor_tracker;

`ifdef E_DEBOUNCE_EN
  localparam int LAT = 19;  // edges from raw press to bts set: 3 + DEBOUNCE_CYCLES
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       ShiftFlr;
  logic       clearFlr;
  logic [3:0] bts;
  logic [3:0] curFlr;
  logic [1:0] flr_idx;
  logic       dir_up;

  e_floor_tracker #(
    .N_FLR           (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .ShiftFlr (ShiftFlr),
    .clearFlr (clearFlr),
    .bts      (bts),
    .curFlr   (curFlr),
    .flr_idx  (flr_idx),
    .dir_up   (dir_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] bts;
    logic [3:0] cur;
    logic [1:0] idx;
    logic       dir;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Monitor: compares one queued expectation per falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_total++;
      if (bts === e.bts && curFlr === e.cur && flr_idx === e.idx && dir_up === e.dir) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got bts=%b curFlr=%b flr_idx=%0d dir_up=%b, expected bts=%b curFlr=%b flr_idx=%0d dir_up=%b",
                 e.name, bts, curFlr, flr_idx, dir_up, e.bts, e.cur, e.idx, e.dir);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation and wait (bounded) for the monitor to consume it.
  task automatic expect_st(input string name, input logic [3:0] b, input logic [3:0] c,
                           input logic [1:0] idx, input logic d);
    exp_t e;
    e.name = name;
    e.bts  = b;
    e.cur  = c;
    e.idx  = idx;
    e.dir  = d;
    q.push_back(e);
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL %s: monitor did not consume expectation within 20 cycles", name);
      q.delete();
    end
  endtask

  task automatic press(input logic [3:0] v);
    btn_raw = v;
    repeat (LAT) tick();
    btn_raw = 4'b0000;
    repeat (LAT + 2) tick();
  endtask

  task automatic shift_pulse();
    ShiftFlr = 1'b1;
    tick();
    ShiftFlr = 1'b0;
  endtask

  task automatic clear_pulse();
    clearFlr = 1'b1;
    tick();
    clearFlr = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst      = 1'b1;
    btn_raw  = 4'b0000;
    ShiftFlr = 1'b0;
    clearFlr = 1'b0;
    tick();
    tick();
    expect_st("reset_hold", 4'b0000, 4'b0001, 2'd0, 1'b1);
    rst = 1'b0;
    repeat (4) tick();
    expect_st("idle_after_reset", 4'b0000, 4'b0001, 2'd0, 1'b1);

    // Request latency and held button
    tick();
    btn_raw = 4'b0100;
    repeat (LAT - 1) tick();
    expect_st("press_before_latency", 4'b0000, 4'b0001, 2'd0, 1'b1);
    tick();
    expect_st("press_latency", 4'b0100, 4'b0001, 2'd0, 1'b1);
    repeat (4) tick();
    expect_st("press_held", 4'b0100, 4'b0001, 2'd0, 1'b1);
    btn_raw = 4'b0000;
    repeat (LAT + 2) tick();

    // Travel up to floor 2 and service it
    shift_pulse();
    expect_st("travel_1", 4'b0100, 4'b0010, 2'd1, 1'b1);
    shift_pulse();
    expect_st("travel_2", 4'b0100, 4'b0100, 2'd2, 1'b1);
    clear_pulse();
    expect_st("clear_f2", 4'b0000, 4'b0100, 2'd2, 1'b1);

    // Top floor and reversal
    press(4'b1000);
    shift_pulse();
    expect_st("travel_top", 4'b1000, 4'b1000, 2'd3, 1'b1);
    clear_pulse();
    expect_st("clear_top", 4'b0000, 4'b1000, 2'd3, 1'b1);
    press(4'b0001);
    expect_st("req_f0", 4'b0001, 4'b1000, 2'd3, 1'b1);
    shift_pulse();
    expect_st("reverse_top", 4'b0001, 4'b0100, 2'd2, 1'b0);
    shift_pulse();
    expect_st("down_1", 4'b0001, 4'b0010, 2'd1, 1'b0);
    shift_pulse();
    expect_st("down_0", 4'b0001, 4'b0001, 2'd0, 1'b0);
    clear_pulse();
    expect_st("clear_f0", 4'b0000, 4'b0001, 2'd0, 1'b0);

    // Idle shift, then reversal at the ground floor
    shift_pulse();
    expect_st("idle_shift", 4'b0000, 4'b0001, 2'd0, 1'b0);
    press(4'b0100);
    shift_pulse();
    expect_st("reverse_bottom", 4'b0100, 4'b0010, 2'd1, 1'b1);

    // Press of current floor while clearing is discarded
    clearFlr = 1'b1;
    btn_raw  = 4'b0010;
    repeat (LAT + 2) tick();
    btn_raw = 4'b0000;
    repeat (LAT + 2) tick();
    clearFlr = 1'b0;
    expect_st("press_during_clear", 4'b0100, 4'b0010, 2'd1, 1'b1);

    // Shift and clear together: shift wins, current-floor request survives
    press(4'b0010);
    expect_st("req_cur_floor", 4'b0110, 4'b0010, 2'd1, 1'b1);
    ShiftFlr = 1'b1;
    clearFlr = 1'b1;
    tick();
    ShiftFlr = 1'b0;
    clearFlr = 1'b0;
    expect_st("shift_and_clear", 4'b0110, 4'b0100, 2'd2, 1'b1);
    clear_pulse();
    expect_st("clear_f2b", 4'b0010, 4'b0100, 2'd2, 1'b1);
    shift_pulse();
    expect_st("reverse_mid", 4'b0010, 4'b0010, 2'd1, 1'b0);
    clear_pulse();
    expect_st("clear_f1", 4'b0000, 4'b0010, 2'd1, 1'b0);

    // Asynchronous reset mid-run, with a button held through reset
    press(4'b1000);
    shift_pulse();
    expect_st("pre_reset", 4'b1000, 4'b0100, 2'd2, 1'b1);
    btn_raw = 4'b1000;
    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_st("async_reset", 4'b0000, 4'b0001, 2'd0, 1'b1);
    tick();
    rst = 1'b0;
    repeat (LAT + 6) tick();
    expect_st("held_through_reset", 4'b0000, 4'b0001, 2'd0, 1'b1);
    btn_raw = 4'b0000;
    repeat (LAT + 2) tick();
    press(4'b1000);
    expect_st("press_after_reset", 4'b1000, 4'b0001, 2'd0, 1'b1);

`ifdef E_DEBOUNCE_EN
    btn_raw = 4'b0010;
    repeat (5) tick();
    btn_raw = 4'b0000;
    repeat (30) tick();
    expect_st("glitch_filtered", 4'b1000, 4'b0001, 2'd0, 1'b1);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
